rr_arbiter_16: RTL

- Round-robin arbiter that shares one 16-way resource (for example a decoded chip-select or bus-select line set) between 16 requesters.
- Issues one grant at a time as a registered 4-bit index plus a one-hot 16-bit select vector.
- Enforces a maximum tenure per grant and rotates priority so no requester starves.
- Sits in front of the 4-to-16 decode path and drives its select index.

---
 rtl/rr_arbiter_16.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/rr_arbiter_16.sv
// Round-robin arbiter for 16 requesters with a bounded grant tenure and a
// mandatory dead cycle between grants; drives a registered index and one-hot select.
module rr_arbiter_16 #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] req,
  output logic        grant_valid,
  output logic [3:0]  grant_idx,
  output logic [15:0] grant,
  output logic        busy
);

  localparam int unsigned N  = 16;
  localparam int unsigned IW = 4;
  localparam int unsigned CW = 8;

  localparam logic [CW-1:0] MAX_HOLD_C = CW'(MAX_HOLD);
  localparam logic [CW-1:0] CNT_SAT    = '1;
  localparam logic [IW-1:0] IDX_LAST   = '1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_GAP   = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic            grant_valid_q, grant_valid_d;
  logic [IW-1:0]   grant_idx_q, grant_idx_d;
  logic [N-1:0]    grant_q, grant_d;
  logic            busy_q, busy_d;
  logic [CW-1:0]   hold_cnt_q, hold_cnt_d;
  logic [IW-1:0]   last_idx_q, last_idx_d;

  logic            win_found;
  logic [IW-1:0]   win_idx;
  logic [IW-1:0]   cand;
  logic            limit_hit;
  logic            owner_req;

  // Rotating first-set search starting just above the last winner.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 0; i < N; i++) begin
      cand = last_idx_q + IW'(i + 1);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign owner_req = req[grant_idx_q];
  assign limit_hit = (MAX_HOLD != 0) && (hold_cnt_q >= MAX_HOLD_C);

  // Next-state and registered output values.
  always_comb begin
    state_d       = state_q;
    grant_valid_d = grant_valid_q;
    grant_idx_d   = grant_idx_q;
    grant_d       = grant_q;
    busy_d        = busy_q;
    hold_cnt_d    = hold_cnt_q;
    last_idx_d    = last_idx_q;

    unique case (state_q)
      S_IDLE: begin
        grant_valid_d = 1'b0;
        grant_d       = '0;
        busy_d        = 1'b0;
        if (en && win_found) begin
          state_d          = S_GRANT;
          grant_valid_d    = 1'b1;
          grant_idx_d      = win_idx;
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
          busy_d           = 1'b1;
          hold_cnt_d       = CW'(1);
          last_idx_d       = win_idx;
        end
      end

      S_GRANT: begin
        if (!owner_req || limit_hit) begin
          state_d       = S_GAP;
          grant_valid_d = 1'b0;
          grant_d       = '0;
          busy_d        = 1'b1;
        end else if (hold_cnt_q != CNT_SAT) begin
          hold_cnt_d = hold_cnt_q + CW'(1);
        end
      end

      S_GAP: begin
        state_d       = S_IDLE;
        grant_valid_d = 1'b0;
        grant_d       = '0;
        busy_d        = 1'b0;
      end

      default: begin
        state_d       = S_IDLE;
        grant_valid_d = 1'b0;
        grant_d       = '0;
        busy_d        = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      grant_valid_q <= 1'b0;
      grant_idx_q   <= '0;
      grant_q       <= '0;
      busy_q        <= 1'b0;
      hold_cnt_q    <= '0;
      last_idx_q    <= IDX_LAST;
    end else begin
      state_q       <= state_d;
      grant_valid_q <= grant_valid_d;
      grant_idx_q   <= grant_idx_d;
      grant_q       <= grant_d;
      busy_q        <= busy_d;
      hold_cnt_q    <= hold_cnt_d;
      last_idx_q    <= last_idx_d;
    end
  end

  assign grant_valid = grant_valid_q;
  assign grant_idx   = grant_idx_q;
  assign grant       = grant_q;
  assign busy        = busy_q;

endmodule
